result_frame_tx: RTL and testbench
==================================

Name: result_frame_tx

Overview:
- Transmit-side framer for the filter result: the counterpart of the receive-side command/parameter/mask/image loader.
- On `start`, reads w*h filtered pixels out of the output memory and drives the byte interface of `uart_tx` as one framed packet.
- Frame: sync byte, w, h, payload, then a one-byte XOR checksum.
- Honours host flow control on `host_rts`, and replaces ad-hoc `start_send` sequencing in the top-level FSM.

Parameters:
- WORD, 8, data/byte width.
- ADDR_BITS, 9, output-memory address width.
- LEN_BITS, 16, payload length/counter width (holds w*h).
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to send a frame; ignored while busy.
- w  input  WORD  image width; sampled on accepted start.
- h  input  WORD  image height; sampled on accepted start.
- mem_addr  output  ADDR_BITS  output-memory read address.
- mem_data  input  WORD  output-memory read data; valid one clk after mem_addr is driven.
- host_rts  input  1  high = host ready to accept the next byte.
- tx_active  input  1  from uart_tx, serializer busy.
- tx_done  input  1  from uart_tx, one-cycle pulse at the end of a byte.
- tx_dv  output  1  one-cycle pulse to uart_tx, start byte.
- tx_byte  output  WORD  byte to uart_tx.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when the frame is complete.
- byte_count  output  LEN_BITS  payload bytes handed to uart_tx in the current/last frame.

Behaviour:
- Reset values:
  - mem_addr=0, tx_dv=0, tx_byte=0, busy=0, done=0, byte_count=0.
  - Checksum accumulator=0, state=IDLE.
- Start acceptance:
  - Start is accepted only in IDLE.
  - On acceptance, latch w, h, and len = w*h (unsigned, LEN_BITS); clear checksum, index and byte_count; busy=1 next cycle.
- States:
  - IDLE: wait for start.
  - HDR: load tx_byte with SYNC_BYTE, then w, then h (header index 0..2).
  - FETCH: drive mem_addr = index[ADDR_BITS-1:0].
  - LOAD: capture mem_data into tx_byte.
  - ARM: wait until host_rts=1 and tx_active=0.
  - SEND: tx_dv=1 for exactly one cycle.
  - WAITD: wait for tx_done.
  - CKSUM: load tx_byte with the checksum, then ARM/SEND/WAITD.
  - FIN: done=1 for one cycle, busy=0, back to IDLE.
- Transitions:
  - IDLE->HDR on start.
  - HDR->ARM after each header byte is loaded.
  - After WAITD on header byte 2: if len=0 go to CKSUM, else FETCH.
  - FETCH->LOAD->ARM.
  - After WAITD on payload: increment index and byte_count; if index=len go to CKSUM, else FETCH.
  - After WAITD on checksum: go to FIN.
- Checksum: XOR of w, h, and every payload byte; SYNC_BYTE is excluded.
- Handshake:
  - tx_byte is stable from one cycle before tx_dv until the matching tx_done.
  - At most one byte is outstanding; the next tx_dv only follows the previous tx_done.
  - tx_dv is never asserted while host_rts=0 or tx_active=1.
- Flow control: host_rts low in ARM stalls indefinitely; no bytes are dropped or duplicated. Deassertion mid-byte does not abort that byte.
- Latency:
  - Accepted start at cycle T gives the SYNC tx_dv at T+2 when the host is ready and uart_tx is idle.
  - Payload byte tx_dv comes no earlier than 3 cycles after the previous tx_done.
- Wrap-around: len may exceed 2^ADDR_BITS; mem_addr wraps modulo 2^ADDR_BITS, while index/byte_count use the full LEN_BITS.
- Zero size: w=0 or h=0 sends the 4-byte frame SYNC, w, h, w^h.
- Simultaneous events:
  - start in the same cycle as done/FIN is ignored; it must be reissued in IDLE.
  - rst has priority over everything.
- Reset mid-frame: return to IDLE next cycle with all outputs at reset values. A byte already in uart_tx completes on its own; its tx_done is ignored in IDLE.

Test Plan:
- Basic frame: w=2, h=2, mem[0..3]=01,02,03,04 -> serial bytes A5 02 02 01 02 03 04 04; byte_count=4; one done pulse after the last tx_done; busy low afterwards.
- Zero size: w=0, h=5 -> exactly A5 00 05 05, mem_addr never leaves 0, done pulse.
- RTS stall: same frame as basic, host_rts=0 for 2000 clk after the 3rd tx_done -> no tx_dv during the stall; resumes with byte 01; full frame intact.
- Busy start: pulse start again during payload -> ignored, single frame sent. Then start in IDLE -> second identical frame.
- Reset mid-frame: rst for 1 clk during payload byte 2 -> tx_dv, busy, done and byte_count all 0. A new start sends a complete frame from SYNC.
- Wrap: w=32, h=20 (len=640), mem[i]=i[7:0] -> payload byte 512 reads mem_addr=0; byte_count=640; checksum equals the XOR computed by the model.

Source files
------------

// File: rtl/result_frame_tx.sv
// result_frame_tx
// Transmit-side framer for the filter result. When start is accepted it sends
// one packet to uart_tx: the sync byte, w, h, the w*h payload bytes read from
// the output memory, and an XOR checksum over w, h and the payload. The sync
// byte is not part of the checksum. Each byte waits in ARM until the host
// raises host_rts and uart_tx is idle.
//
// Ports
//   clk, rst           system clock, synchronous active-high reset
//   start              one-cycle frame request, accepted only in IDLE
//   w, h               image size, sampled when start is accepted
//   mem_addr/mem_data  output-memory read port; data is valid one clk after the address
//   host_rts           host is ready to accept the next byte
//   tx_active/tx_done  status from uart_tx
//   tx_dv/tx_byte      byte hand-off to uart_tx
//   busy, done         frame in progress, and a one-cycle pulse when the frame is complete
//   byte_count         payload bytes completed in the current or last frame
//
// state  | meaning
// IDLE   | wait for start
// HDR    | load header byte hdr_idx (0 sync, 1 w, 2 h)
// FETCH  | memory read of mem_addr in flight
// LOAD   | capture mem_data into tx_byte
// ARM    | wait for host_rts=1 and tx_active=0
// SEND   | tx_dv pulse
// WAITD  | wait for tx_done, then pick the next byte
// CKSUM  | load the checksum byte
// FIN    | done pulse, then back to IDLE
module result_frame_tx #(
    parameter int              WORD      = 8,
    parameter int              ADDR_BITS = 9,
    parameter int              LEN_BITS  = 16,
    parameter logic [WORD-1:0] SYNC_BYTE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WORD-1:0]      w,
    input  logic [WORD-1:0]      h,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [WORD-1:0]      mem_data,
    input  logic                 host_rts,
    input  logic                 tx_active,
    input  logic                 tx_done,
    output logic                 tx_dv,
    output logic [WORD-1:0]      tx_byte,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_BITS-1:0]  byte_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_FETCH, S_LOAD, S_ARM, S_SEND, S_WAITD, S_CKSUM, S_FIN
    } state_t;

    // phase records which kind of byte is in flight, so WAITD knows where to go next
    typedef enum logic [1:0] {PH_HDR, PH_PAY, PH_CK} phase_t;

    state_t              state, next_state;
    phase_t              phase;
    logic [1:0]          hdr_idx;
    logic [WORD-1:0]     w_q, h_q, cksum;
    logic [LEN_BITS-1:0] len_q, idx;
    logic [LEN_BITS-1:0] idx_inc;

    assign idx_inc = idx + LEN_BITS'(1);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_HDR;
            S_HDR:   next_state = S_ARM;
            S_FETCH: next_state = S_LOAD;
            S_LOAD:  next_state = S_ARM;
            S_ARM:   if (host_rts && !tx_active) next_state = S_SEND;
            S_SEND:  next_state = S_WAITD;
            S_WAITD: begin
                if (tx_done) begin
                    case (phase)
                        PH_HDR: begin
                            if (hdr_idx == 2'd2)
                                next_state = (len_q == '0) ? S_CKSUM : S_FETCH;
                            else
                                next_state = S_HDR;
                        end
                        PH_PAY:  next_state = (idx_inc == len_q) ? S_CKSUM : S_FETCH;
                        default: next_state = S_FIN;
                    endcase
                end
            end
            S_CKSUM: next_state = S_ARM;
            S_FIN:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign tx_dv = (state == S_SEND);
    assign done  = (state == S_FIN);
    assign busy  = (state != S_IDLE) && (state != S_FIN);

    // mem_addr changes on the tx_done edge that leaves WAITD. This gives the
    // memory the whole FETCH cycle to return data before LOAD captures it.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr   <= '0;
            tx_byte    <= '0;
            byte_count <= '0;
            cksum      <= '0;
            idx        <= '0;
            len_q      <= '0;
            w_q        <= '0;
            h_q        <= '0;
            hdr_idx    <= '0;
            phase      <= PH_HDR;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        w_q        <= w;
                        h_q        <= h;
                        len_q      <= LEN_BITS'(w) * LEN_BITS'(h);
                        cksum      <= '0;
                        idx        <= '0;
                        byte_count <= '0;
                        hdr_idx    <= '0;
                        mem_addr   <= '0;
                        phase      <= PH_HDR;
                    end
                end
                S_HDR: begin
                    case (hdr_idx)
                        2'd0: tx_byte <= SYNC_BYTE;
                        2'd1: begin
                            tx_byte <= w_q;
                            cksum   <= cksum ^ w_q;
                        end
                        default: begin
                            tx_byte <= h_q;
                            cksum   <= cksum ^ h_q;
                        end
                    endcase
                end
                S_LOAD: begin
                    tx_byte <= mem_data;
                    cksum   <= cksum ^ mem_data;
                    phase   <= PH_PAY;
                end
                S_CKSUM: begin
                    tx_byte <= cksum;
                    phase   <= PH_CK;
                end
                S_WAITD: begin
                    if (tx_done) begin
                        case (phase)
                            PH_HDR: begin
                                hdr_idx  <= hdr_idx + 2'd1;
                                mem_addr <= idx[ADDR_BITS-1:0];
                            end
                            PH_PAY: begin
                                // the address wraps with the memory; the count does not
                                idx        <= idx_inc;
                                byte_count <= idx_inc;
                                mem_addr   <= idx_inc[ADDR_BITS-1:0];
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_result_frame_tx.sv
module tb_result_frame_tx;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [7:0]  w, h;
    logic [8:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        host_rts, tx_active, tx_done;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        busy, done;
    logic [15:0] byte_count;

    result_frame_tx dut (
        .clk(clk), .rst(rst), .start(start), .w(w), .h(h),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .host_rts(host_rts), .tx_active(tx_active), .tx_done(tx_done),
        .tx_dv(tx_dv), .tx_byte(tx_byte),
        .busy(busy), .done(done), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_vec++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got_v, exp_v);
        end
    endtask

    // output memory: synchronous read
    logic [7:0] mem [512];
    always @(posedge clk) mem_data <= mem[mem_addr];

    // uart_tx stand-in: tx_active for a random number of cycles, then a tx_done pulse
    initial begin
        tx_active = 1'b0;
        tx_done   = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (tx_dv) begin
                tx_active = 1'b1;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
                tx_active = 1'b0;
                tx_done   = 1'b1;
                @(posedge clk); #1;
                tx_done = 1'b0;
            end
        end
    end

    // host flow control
    bit rts_rand = 1'b0;
    bit stall    = 1'b0;
    initial begin
        host_rts = 1'b1;
        forever begin
            @(posedge clk); #1;
            host_rts = stall ? 1'b0 : (rts_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // protocol monitor
    logic [7:0] got[$];
    int   n_txdv = 0, n_txdone = 0, done_cnt = 0;
    bit   outstanding = 1'b0, addr_moved = 1'b0;
    logic [7:0] held = '0, prev_byte = '0;
    logic prev_rts = 1'b0, prev_act = 1'b0;

    always @(negedge clk) begin
        if (tx_dv) begin
            chk("dv_allowed", 32'({prev_rts, prev_act, outstanding}), 32'(3'b100));
            chk("byte_setup", 32'(tx_byte), 32'(prev_byte));
            got.push_back(tx_byte);
            outstanding = 1'b1;
            held = tx_byte;
            n_txdv++;
        end
        if (tx_done) begin
            if (outstanding) chk("byte_hold", 32'(tx_byte), 32'(held));
            outstanding = 1'b0;
            n_txdone++;
        end
        if (done) done_cnt++;
        if (busy && mem_addr != 9'd0) addr_moved = 1'b1;
        if (rst) outstanding = 1'b0;
        prev_byte = tx_byte;
        prev_rts  = host_rts;
        prev_act  = tx_active;
    end

    task automatic wait_uart_idle();
        for (int k = 0; k < 200 && (tx_active || tx_done); k++) @(posedge clk);
        @(posedge clk);
    endtask

    task automatic fill_mem(input int mode);
        for (int i = 0; i < 512; i++)
            case (mode)
                0:       mem[i] = 8'(i + 1);
                1:       mem[i] = 8'(i);
                default: mem[i] = 8'($urandom);
            endcase
    endtask

    task automatic pulse_start(input logic [7:0] fw, input logic [7:0] fh);
        @(posedge clk); #1;
        w = fw; h = fh; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] fw, input logic [7:0] fh, input int mode,
                             input bit stall_en, input bit busy_en, input bit lat_en,
                             input bit rts_r, input bit has_ck,
                             input logic [7:0] exp_ck, input logic [15:0] exp_cnt);
        logic [7:0] expq[$];
        logic [7:0] ck;
        int  len, base;
        bit  seen;
        wait_uart_idle();
        if (mode >= 0) fill_mem(mode);
        // reference frame built straight from the packet definition
        len = int'(fw) * int'(fh);
        expq = {8'hA5, fw, fh};
        ck = fw ^ fh;
        for (int i = 0; i < len; i++) begin
            expq.push_back(mem[i % 512]);
            ck ^= mem[i % 512];
        end
        expq.push_back(ck);

        got.delete();
        done_cnt   = 0;
        addr_moved = 1'b0;
        rts_rand   = rts_r;
        base = n_txdone;
        pulse_start(fw, fh);
        if (lat_en) begin
            @(negedge clk);
            chk("busy_after_start", 32'(busy), 32'(1));
            chk("dv_t0", 32'(tx_dv), 32'(0));
            @(negedge clk);
            chk("dv_t1", 32'(tx_dv), 32'(0));
            @(negedge clk);
            chk("dv_t2_sync", 32'(tx_dv), 32'(1));
        end
        if (stall_en) begin
            for (int k = 0; k < 5000 && n_txdone < base + 3; k++) @(negedge clk);
            chk("stall_reached", 32'(n_txdone >= base + 3), 32'(1));
            stall = 1'b1;
            repeat (2000) @(posedge clk);
            chk("stall_no_bytes", 32'(got.size()), 32'(3));
            stall = 1'b0;
        end
        if (busy_en) begin
            base = n_txdv;
            for (int k = 0; k < 5000 && n_txdv < base + 2; k++) @(negedge clk);
            @(posedge clk); #1;
            w = 8'd9; h = 8'd9; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        seen = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'(1));
        if (seen) begin
            chk("busy_at_done", 32'(busy), 32'(0));
            if (busy_en) begin
                // start coincident with done must be dropped
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        repeat (30) @(negedge clk);
        chk("done_pulses", 32'(done_cnt), 32'(1));
        chk("busy_idle", 32'(busy), 32'(0));
        chk("byte_count", 32'(byte_count), 32'(exp_cnt));
        chk("frame_len", 32'(got.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++) begin
            n_vec++;
            if (got[i] !== expq[i]) begin
                n_bad++;
                if (n_bad < 20) $display("FAIL frame_byte[%0d]: got %0h expected %0h", i, got[i], expq[i]);
            end
        end
        if (has_ck && got.size() > 0) chk("checksum", 32'(got[got.size()-1]), 32'(exp_ck));
        if (len == 0) chk("addr_stays_0", 32'(addr_moved), 32'(0));
        rts_rand = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  w, h;
        int          mode;
        bit          stall_en, busy_en, lat_en;
        logic [7:0]  ck;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{w:8'd2,  h:8'd2,  mode:0, stall_en:1'b0, busy_en:1'b0, lat_en:1'b1, ck:8'h04, cnt:16'd4};
        tbl[1] = '{w:8'd0,  h:8'd5,  mode:0, stall_en:1'b0, busy_en:1'b0, lat_en:1'b1, ck:8'h05, cnt:16'd0};
        tbl[2] = '{w:8'd2,  h:8'd2,  mode:0, stall_en:1'b1, busy_en:1'b0, lat_en:1'b0, ck:8'h04, cnt:16'd4};
        tbl[3] = '{w:8'd2,  h:8'd2,  mode:0, stall_en:1'b0, busy_en:1'b1, lat_en:1'b0, ck:8'h04, cnt:16'd4};
        tbl[4] = '{w:8'd2,  h:8'd2,  mode:0, stall_en:1'b0, busy_en:1'b0, lat_en:1'b1, ck:8'h04, cnt:16'd4};
        tbl[5] = '{w:8'd32, h:8'd20, mode:1, stall_en:1'b0, busy_en:1'b0, lat_en:1'b1, ck:8'h34, cnt:16'd640};
        tbl[6] = '{w:8'd5,  h:8'd0,  mode:0, stall_en:1'b0, busy_en:1'b0, lat_en:1'b0, ck:8'h05, cnt:16'd0};
        tbl[7] = '{w:8'd1,  h:8'd1,  mode:0, stall_en:1'b0, busy_en:1'b0, lat_en:1'b0, ck:8'h01, cnt:16'd1};

        fill_mem(0);
        rst = 1'b1; start = 1'b0; w = '0; h = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_dv", 32'(tx_dv), 32'(0));
        chk("rst_tx_byte", 32'(tx_byte), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_byte_count", 32'(byte_count), 32'(0));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        rst = 1'b0;

        for (int t = 0; t < 8; t++)
            run_frame(tbl[t].w, tbl[t].h, tbl[t].mode, tbl[t].stall_en, tbl[t].busy_en,
                      tbl[t].lat_en, 1'b0, 1'b1, tbl[t].ck, tbl[t].cnt);

        // reset while payload byte 2 is on the wire
        wait_uart_idle();
        fill_mem(0);
        begin
            int base;
            base = n_txdv;
            pulse_start(8'd3, 8'd2);
            for (int k = 0; k < 5000 && n_txdv < base + 5; k++) @(negedge clk);
            chk("reached_payload2", 32'(n_txdv >= base + 5), 32'(1));
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk("mid_rst_tx_dv", 32'(tx_dv), 32'(0));
            chk("mid_rst_busy", 32'(busy), 32'(0));
            chk("mid_rst_done", 32'(done), 32'(0));
            chk("mid_rst_byte_count", 32'(byte_count), 32'(0));
            chk("mid_rst_tx_byte", 32'(tx_byte), 32'(0));
        end
        // checksum: 3^2 ^ (1^2^3^4^5^6) = 06
        run_frame(8'd3, 8'd2, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h06, 16'd6);

        // random sizes, random memory, host_rts toggling
        for (int r = 0; r < 8; r++) begin
            logic [7:0] rw, rh;
            rw = 8'($urandom_range(0, 12));
            rh = 8'($urandom_range(0, 12));
            run_frame(rw, rh, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'(rw) * 16'(rh));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
